// File: rtl/evict_addr_builder.sv
// Rebuilds L1/L2 victim line addresses and queues them for write-back.
// Optional WB_ADDR_PARITY_EN adds a per-entry even-parity bit on wb_par.
module evict_addr_builder #(
  parameter int ADDW    = 16,
  parameter int TAGWID1 = 3,
  parameter int SETWID1 = 9,
  parameter int TAGWID2 = 2,
  parameter int SETWID2 = 10,
  parameter int DEPTH   = 4,
  parameter int CNTW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               l1_evict,
  input  logic [TAGWID1-1:0] l1_tag,
  input  logic [SETWID1-1:0] l1_set,
  input  logic               l2_evict,
  input  logic [TAGWID2-1:0] l2_tag,
  input  logic [SETWID2-1:0] l2_set,
  output logic               l2_busy,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [ADDW-1:0]    wb_addr,
  output logic               wb_src,
  output logic [CNTW-1:0]    count,
  output logic               overflow
`ifdef WB_ADDR_PARITY_EN
  ,output logic              wb_par
`endif
);

  localparam int OFF1 = ADDW - TAGWID1 - SETWID1;
  localparam int OFF2 = ADDW - TAGWID2 - SETWID2;
  localparam int PW   = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  if (OFF1 < 0) begin : g_off1_err
    $error("L1 tag+set wider than ADDW");
  end
  if (OFF2 < 0) begin : g_off2_err
    $error("L2 tag+set wider than ADDW");
  end

  logic [ADDW-1:0] l1_addr;
  logic [ADDW-1:0] l2_addr;

  assign l1_addr = (ADDW'(l1_tag) << (SETWID1 + OFF1))
                 | (ADDW'(l1_set) << OFF1);
  assign l2_addr = (ADDW'(l2_tag) << (SETWID2 + OFF2))
                 | (ADDW'(l2_set) << OFF2);

  logic [ADDW-1:0] mem_addr_q [DEPTH];
  logic            mem_src_q  [DEPTH];
`ifdef WB_ADDR_PARITY_EN
  logic            mem_par_q  [DEPTH];
`endif
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            hold_v_q, hold_v_d;
  logic [ADDW-1:0] hold_addr_q, hold_addr_d;
  logic            ovf_q, ovf_d;

  logic            pop;
  logic            space;
  logic            push;
  logic [ADDW-1:0] push_addr;
  logic            push_src;
  logic            drop;

  assign wb_valid = (count_q != '0);
  assign pop      = wb_valid & wb_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign space    = (count_q != FULL) | pop;

  always_comb begin
    push        = 1'b0;
    push_addr   = l1_addr;
    push_src    = 1'b0;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    drop        = 1'b0;
    if (l1_evict) begin
      if (space) push = 1'b1;
      else       drop = 1'b1;
      if (l2_evict) begin
        if (!hold_v_q) begin
          hold_v_d    = 1'b1;
          hold_addr_d = l2_addr;
        end else begin
          drop = 1'b1;
        end
      end
    end else if (hold_v_q) begin
      if (space) begin
        push      = 1'b1;
        push_addr = hold_addr_q;
        push_src  = 1'b1;
        hold_v_d  = 1'b0;
      end
      // Draining frees the hold slot for a same-cycle L2 victim.
      if (l2_evict) begin
        if (space) begin
          hold_v_d    = 1'b1;
          hold_addr_d = l2_addr;
        end else begin
          drop = 1'b1;
        end
      end
    end else if (l2_evict) begin
      if (space) begin
        push      = 1'b1;
        push_addr = l2_addr;
        push_src  = 1'b1;
      end else begin
        hold_v_d    = 1'b1;
        hold_addr_d = l2_addr;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  assign ovf_d = ovf_q | drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      ovf_q       <= ovf_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_src_q[i]  <= 1'b0;
      end
    end else if (push) begin
      mem_addr_q[wptr_q] <= push_addr;
      mem_src_q[wptr_q]  <= push_src;
    end
  end

`ifdef WB_ADDR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_par_q[i] <= 1'b0;
    end else if (push) begin
      mem_par_q[wptr_q] <= ^push_addr;
    end
  end

  assign wb_par = wb_valid ? mem_par_q[rptr_q] : 1'b0;
`endif

  assign wb_addr  = wb_valid ? mem_addr_q[rptr_q] : '0;
  assign wb_src   = wb_valid ? mem_src_q[rptr_q] : 1'b0;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign l2_busy  = hold_v_q;

endmodule

// File: tb/tb_evict_addr_builder.sv
// Directed bench for evict_addr_builder: rebuild, ordering, full/overflow.
// Checks wb_par as well when WB_ADDR_PARITY_EN is defined.
module tb_evict_addr_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        l1_evict;
  logic [2:0]  l1_tag;
  logic [8:0]  l1_set;
  logic        l2_evict;
  logic [1:0]  l2_tag;
  logic [9:0]  l2_set;
  logic        l2_busy;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_addr;
  logic        wb_src;
  logic [2:0]  count;
  logic        overflow;
`ifdef WB_ADDR_PARITY_EN
  logic        wb_par;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] fill_exp [4];

  evict_addr_builder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .l1_evict (l1_evict),
    .l1_tag   (l1_tag),
    .l1_set   (l1_set),
    .l2_evict (l2_evict),
    .l2_tag   (l2_tag),
    .l2_set   (l2_set),
    .l2_busy  (l2_busy),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_src   (wb_src),
    .count    (count),
    .overflow (overflow)
`ifdef WB_ADDR_PARITY_EN
    ,.wb_par  (wb_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    l1_evict = 1'b0;
    l2_evict = 1'b0;
    wb_ready = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // Four L1 victims: 0x0110, 0x2220, 0x4330, 0x6440.
  task automatic fill_l1(input int n);
    logic [2:0] tg [4];
    logic [8:0] st [4];
    tg[0] = 3'd0; st[0] = 9'h011;
    tg[1] = 3'd1; st[1] = 9'h022;
    tg[2] = 3'd2; st[2] = 9'h033;
    tg[3] = 3'd3; st[3] = 9'h044;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      l1_evict = 1'b1;
      l1_tag   = tg[i];
      l1_set   = st[i];
    end
    @(negedge clk);
    l1_evict = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", wb_valid); end
    checks++; if (wb_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0000", wb_addr); end
    checks++; if (wb_src !== 1'b0) begin errors++; $display("FAIL rst_src got %b exp 0", wb_src); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", l2_busy); end
`ifdef WB_ADDR_PARITY_EN
    checks++; if (wb_par !== 1'b0) begin errors++; $display("FAIL rst_par got %b exp 0", wb_par); end
`endif
  endtask

  task automatic test_l1_rebuild;
    wb_ready = 1'b1;
    l1_evict = 1'b1; l1_tag = 3'b101; l1_set = 9'h1A3;
    @(negedge clk);
    l1_evict = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL l1_valid got %b exp 1", wb_valid); end
    checks++; if (wb_addr !== 16'hBA30) begin errors++; $display("FAIL l1_addr got %h exp ba30", wb_addr); end
    checks++; if (wb_src !== 1'b0) begin errors++; $display("FAIL l1_src got %b exp 0", wb_src); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL l1_count got %0d exp 1", count); end
`ifdef WB_ADDR_PARITY_EN
    checks++; if (wb_par !== 1'b1) begin errors++; $display("FAIL l1_par got %b exp 1", wb_par); end
`endif
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL l1_pop_valid got %b exp 0", wb_valid); end
    checks++; if (wb_addr !== 16'h0) begin errors++; $display("FAIL l1_pop_addr got %h exp 0000", wb_addr); end
  endtask

  task automatic test_l2_rebuild;
    wb_ready = 1'b1;
    l2_evict = 1'b1; l2_tag = 2'b10; l2_set = 10'h3C5;
    @(negedge clk);
    l2_evict = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL l2_valid got %b exp 1", wb_valid); end
    checks++; if (wb_addr !== 16'hBC50) begin errors++; $display("FAIL l2_addr got %h exp bc50", wb_addr); end
    checks++; if (wb_src !== 1'b1) begin errors++; $display("FAIL l2_src got %b exp 1", wb_src); end
    checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL l2_busy got %b exp 0", l2_busy); end
`ifdef WB_ADDR_PARITY_EN
    checks++; if (wb_par !== 1'b1) begin errors++; $display("FAIL l2_par got %b exp 1", wb_par); end
`endif
    @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL l2_pop_count got %0d exp 0", count); end
  endtask

  task automatic test_simultaneous;
    wb_ready = 1'b0;
    l1_evict = 1'b1; l1_tag = 3'b101; l1_set = 9'h1A3;
    l2_evict = 1'b1; l2_tag = 2'b10;  l2_set = 10'h3C5;
    @(negedge clk);
    l1_evict = 1'b0; l2_evict = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL sim_count1 got %0d exp 1", count); end
    checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL sim_busy1 got %b exp 1", l2_busy); end
    checks++; if (wb_addr !== 16'hBA30) begin errors++; $display("FAIL sim_head1 got %h exp ba30", wb_addr); end
    @(negedge clk);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL sim_count2 got %0d exp 2", count); end
    checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL sim_busy2 got %b exp 0", l2_busy); end
    checks++; if (wb_addr !== 16'hBA30) begin errors++; $display("FAIL sim_stall got %h exp ba30", wb_addr); end
    wb_ready = 1'b1;
    @(negedge clk);
    checks++; if (wb_addr !== 16'hBC50) begin errors++; $display("FAIL sim_head2 got %h exp bc50", wb_addr); end
    checks++; if (wb_src !== 1'b1) begin errors++; $display("FAIL sim_src2 got %b exp 1", wb_src); end
    @(negedge clk);
    wb_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sim_empty got %0d exp 0", count); end
  endtask

  task automatic test_full;
    logic [15:0] exp2 [4];
    do_reset();
    fill_l1(4);
    l1_evict = 1'b1; l1_tag = 3'd7; l1_set = 9'h1FF;
    @(negedge clk);
    l1_evict = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b exp 1", overflow); end
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (wb_addr !== fill_exp[k]) begin errors++; $display("FAIL full_drain%0d got %h exp %h", k, wb_addr, fill_exp[k]); end
      @(negedge clk);
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL full_dropped got valid %b addr %h exp empty", wb_valid, wb_addr); end

    do_reset();
    fill_l1(4);
    l1_evict = 1'b1; l1_tag = 3'd7; l1_set = 9'h1FF;
    wb_ready = 1'b1;
    @(negedge clk);
    l1_evict = 1'b0;
    wb_ready = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_count got %0d exp 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", overflow); end
    exp2[0] = 16'h2220; exp2[1] = 16'h4330;
    exp2[2] = 16'h6440; exp2[3] = 16'hFFF0;
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (wb_addr !== exp2[k]) begin errors++; $display("FAIL fullpop_drain%0d got %h exp %h", k, wb_addr, exp2[k]); end
      @(negedge clk);
    end
    wb_ready = 1'b0;
  endtask

  task automatic test_hold_overflow;
    logic [15:0] exp2 [4];
    do_reset();
    fill_l1(4);
    l2_evict = 1'b1; l2_tag = 2'd1; l2_set = 10'h001;
    @(negedge clk);
    checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b exp 1", l2_busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hold_ovf0 got %b exp 0", overflow); end
    l2_tag = 2'd2; l2_set = 10'h002;
    @(negedge clk);
    l2_evict = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL hold_ovf1 got %b exp 1", overflow); end
    checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL hold_kept got %b exp 1", l2_busy); end
    wb_ready = 1'b1;
    @(negedge clk);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL hold_drain_count got %0d exp 4", count); end
    checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL hold_drained got %b exp 0", l2_busy); end
    exp2[0] = 16'h2220; exp2[1] = 16'h4330;
    exp2[2] = 16'h6440; exp2[3] = 16'h4010;
    for (int k = 0; k < 4; k++) begin
      checks++; if (wb_addr !== exp2[k]) begin errors++; $display("FAIL hold_order%0d got %h exp %h", k, wb_addr, exp2[k]); end
      @(negedge clk);
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL hold_empty got %b exp 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    fill_l1(3);
    l1_evict = 1'b1; l1_tag = 3'd5; l1_set = 9'h0AA;
    l2_evict = 1'b1; l2_tag = 2'd3; l2_set = 10'h155;
    @(negedge clk);
    l2_evict = 1'b0;
    @(negedge clk);
    l1_evict = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL mid_count got %0d exp 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf got %b exp 1", overflow); end
    checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", l2_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", wb_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got %b exp 0", overflow); end
    checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", l2_busy); end
    checks++; if (wb_addr !== 16'h0) begin errors++; $display("FAIL arst_addr got %h exp 0000", wb_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", wb_valid); end
  endtask

  initial begin
    fill_exp[0] = 16'h0110; fill_exp[1] = 16'h2220;
    fill_exp[2] = 16'h4330; fill_exp[3] = 16'h6440;
    rst_n = 1'b0;
    l1_evict = 1'b0; l1_tag = '0; l1_set = '0;
    l2_evict = 1'b0; l2_tag = '0; l2_set = '0;
    wb_ready = 1'b0;
    #12 rst_n = 1'b1;
    test_reset();
    test_l1_rebuild();
    test_l2_rebuild();
    test_simultaneous();
    test_full();
    test_hold_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/evict_addr_builder.md
Name: evict_addr_builder

Overview:
- Reverse of the cache address split. Rebuilds full 16-bit line addresses from {tag, set} pairs for L1 and L2 victim lines.
- Queues the rebuilt addresses in a small FIFO and presents them to the write-back path over a valid/ready handshake.
- Sits between the L1/L2 replacement logic and the memory write-back controller.

Parameters:
- ADDW, 16, full address width
- TAGWID1, 3, L1 tag width
- SETWID1, 9, L1 set-index width
- TAGWID2, 2, L2 tag width
- SETWID2, 10, L2 set-index width
- DEPTH, 4, FIFO entries; power of 2, at least 2
- CNTW, 3, occupancy counter width, equal to log2(DEPTH)+1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- l1_evict  in  1  L1 victim strobe, sampled on posedge clk
- l1_tag  in  TAGWID1  L1 victim tag
- l1_set  in  SETWID1  L1 victim set index
- l2_evict  in  1  L2 victim strobe, sampled on posedge clk
- l2_tag  in  TAGWID2  L2 victim tag
- l2_set  in  SETWID2  L2 victim set index
- l2_busy  out  1  L2 hold register occupied; L2 source must not strobe
- wb_valid  out  1  FIFO head valid
- wb_ready  in  1  write-back controller accepts head
- wb_addr  out  ADDW  rebuilt line address at head
- wb_src  out  1  level of head entry: 0 = L1, 1 = L2
- count  out  CNTW  FIFO occupancy
- overflow  out  1  sticky: an eviction was dropped

Behaviour:
- Address rebuild:
  - L1: {l1_tag, l1_set, OFF1 zeros}, with OFF1 = ADDW-TAGWID1-SETWID1 (4 bits at defaults).
  - L2: {l2_tag, l2_set, OFF2 zeros}, with OFF2 = 4 at defaults.
  - A negative offset width is an elaboration error.
- Reset (rst_n low, async):
  - wb_valid=0, wb_addr=0, wb_src=0, count=0, overflow=0, l2_busy=0.
  - Pointers and hold register are cleared.
  - Any in-flight entries are discarded.
- FIFO read side:
  - First-word-fall-through. wb_addr and wb_src reflect the head whenever wb_valid=1, and are 0 when empty.
  - Pop occurs on a posedge where wb_valid & wb_ready.
  - wb_addr stays stable while wb_valid & !wb_ready.
- FIFO write side: one write port, one write per cycle. Write priority is:
  1. new L1 eviction
  2. L2 hold register
  3. new L2 eviction
- L2 path:
  - If a new L2 eviction is not written directly, it is loaded into the 1-entry hold register and l2_busy=1 from the next cycle.
  - The hold register drains on the first cycle the write port is free.
- Space check:
  - A write is allowed if count<DEPTH, or if count==DEPTH and a pop occurs the same cycle.
  - Otherwise: an L1 eviction is dropped and overflow sets. An L2 eviction goes to the hold register if it is free.
- Overflow on L2:
  - l2_evict while the hold register is occupied and not draining that cycle: the new L2 eviction is dropped and overflow sets.
  - The hold register contents are kept.
- Latency:
  - A strobe sampled at edge N with a free write port gives wb_valid=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- Simultaneous l1_evict and l2_evict: L1 is written at edge N, L2 is held, and L2 is written at edge N+1 if the port is free.
- Simultaneous push and pop: count is unchanged.
- Pointers wrap modulo DEPTH. count saturates at neither end (it cannot exceed DEPTH by construction).
- overflow clears only on reset.

Optional Feature:
- Macro WB_ADDR_PARITY_EN.
- Defined:
  - Extra output wb_par (1 bit) = XOR of all wb_addr bits, so {wb_addr, wb_par} has even parity.
  - Parity is computed at write time and stored per entry.
  - wb_par = 0 when empty and at reset.
- Undefined: no wb_par port and no parity storage.

Test Plan:
- Reset mid-traffic: fill 3 entries, pulse rst_n low asynchronously between edges -> immediately wb_valid=0, count=0, overflow=0, l2_busy=0.
- L1 rebuild: l1_tag=3'b101, l1_set=9'h1A3, wb_ready=1 -> next cycle wb_valid=1, wb_addr=16'hBA30, wb_src=0. With WB_ADDR_PARITY_EN, wb_par=1.
- L2 rebuild: l2_tag=2'b10, l2_set=10'h3C5 -> wb_addr=16'hBC50, wb_src=1.
- Simultaneous evictions: L1 (0xBA30) and L2 (0xBC50) in the same cycle, wb_ready=0 -> l2_busy=1 for one cycle, count goes 1 then 2, drain order is 0xBA30 then 0xBC50.
- Full FIFO: wb_ready=0, 4 L1 evictions then a 5th -> count=4, overflow=1, 5th address never appears. Repeat with wb_ready=1 on the 5th -> accepted, count stays 4, overflow=0.
- Hold-register overflow: wb_ready=0, FIFO full, two back-to-back l2_evict -> first is held (l2_busy=1), second is dropped (overflow=1). Assert wb_ready -> held entry is written once space frees.
